// File: rtl/shim_trigger_pkg.sv
// Shared types for the trigger log reader: FSM encoding, log word and timestamp widths.
package shim_trigger_pkg;

    localparam int TS_WIDTH             = 64;
    localparam int LOG_WORDS_PER_RECORD = 2;
    localparam int LOG_WORD_WIDTH       = TS_WIDTH / LOG_WORDS_PER_RECORD;

    typedef logic [LOG_WORD_WIDTH-1:0] log_word_t;
    typedef logic [TS_WIDTH-1:0]       ts_t;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_LOW   = 2'd1,
        S_HIGH  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    // The trigger core writes the low half first, so the later word is the high half.
    function automatic ts_t join_words(input log_word_t hi, input log_word_t lo);
        return {hi, lo};
    endfunction

endpackage

// File: rtl/shim_ts_delta.sv
// Combinational interval between a new timestamp and the previous accepted one.
// A zero timestamp or a missing predecessor starts a new timeline.
module shim_ts_delta
    import shim_trigger_pkg::*;
#(
    parameter int DELTA_WIDTH = 32
) (
    input  logic [TS_WIDTH-1:0]    ts,
    input  logic [TS_WIDTH-1:0]    prev_ts,
    input  logic                   prev_valid,
    output logic [DELTA_WIDTH-1:0] delta,
    output logic                   first,
    output logic                   saturated,
    output logic                   non_monotonic
);

    logic [TS_WIDTH-1:0] diff;
    logic                diff_hi;

    assign diff = ts - prev_ts;

    generate
        if (DELTA_WIDTH < TS_WIDTH) begin : g_clamp
            assign diff_hi = |diff[TS_WIDTH-1:DELTA_WIDTH];
        end else begin : g_full
            assign diff_hi = 1'b0;
        end
    endgenerate

    always_comb begin
        delta         = '0;
        first         = 1'b0;
        saturated     = 1'b0;
        non_monotonic = 1'b0;
        if (ts == '0 || !prev_valid) begin
            first = 1'b1;
        end else if (ts >= prev_ts) begin
            if (diff_hi) begin
                delta     = '1;
                saturated = 1'b1;
            end else begin
                delta = diff[DELTA_WIDTH-1:0];
            end
        end else begin
            non_monotonic = 1'b1;
        end
    end

endmodule

// File: rtl/shim_trigger_log_reader.sv
// Pairs trigger log words into 64-bit timestamps with intervals; ts_valid one cycle after the high-word pop.
// No pops while a record is held; the record and its outputs stay frozen until ts_ready.
module shim_trigger_log_reader
    import shim_trigger_pkg::*;
#(
    parameter int DELTA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    output logic                      data_word_rd_en,
    input  logic [LOG_WORD_WIDTH-1:0] data_word,
    input  logic                      data_buf_empty,
    input  logic                      clear,
    output logic                      ts_valid,
    input  logic                      ts_ready,
    output logic [TS_WIDTH-1:0]       ts_timestamp,
    output logic [DELTA_WIDTH-1:0]    ts_delta,
    output logic                      ts_first,
    output logic [31:0]               record_count,
    output logic                      non_monotonic,
    output logic                      delta_saturated
);

    state_t                   state;
    state_t                   state_nxt;
    logic [LOG_WORD_WIDTH-1:0] low_reg;
    logic [TS_WIDTH-1:0]      prev_ts;
    logic                     prev_valid;
    logic [TS_WIDTH-1:0]      new_ts;
    logic [DELTA_WIDTH-1:0]   new_delta;
    logic                     new_first;
    logic                     new_saturated;
    logic                     new_non_monotonic;
    logic                     pop_low;
    logic                     pop_high;
    logic                     accept;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        data_word_rd_en = 1'b0;
        ts_valid        = 1'b0;
        case (state)
            S_RESET: state_nxt = S_LOW;
            S_LOW: begin
                if (!data_buf_empty) begin
                    data_word_rd_en = 1'b1;
                    state_nxt       = S_HIGH;
                end
            end
            S_HIGH: begin
                if (!data_buf_empty) begin
                    data_word_rd_en = 1'b1;
                    state_nxt       = S_OUT;
                end
            end
            S_OUT: begin
                ts_valid = 1'b1;
                if (ts_ready) begin
                    state_nxt = S_LOW;
                end
            end
            default: state_nxt = S_RESET;
        endcase
    end

    assign pop_low  = data_word_rd_en && (state == S_LOW);
    assign pop_high = data_word_rd_en && (state == S_HIGH);
    assign accept   = ts_valid && ts_ready;
    assign new_ts   = join_words(data_word, low_reg);

    shim_ts_delta #(
        .DELTA_WIDTH (DELTA_WIDTH)
    ) u_delta (
        .ts            (new_ts),
        .prev_ts       (prev_ts),
        .prev_valid    (prev_valid),
        .delta         (new_delta),
        .first         (new_first),
        .saturated     (new_saturated),
        .non_monotonic (new_non_monotonic)
    );

    // Record registers only load on the high-word pop, so they are frozen throughout S_OUT.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            low_reg      <= '0;
            ts_timestamp <= '0;
            ts_delta     <= '0;
            ts_first     <= 1'b0;
            prev_ts      <= '0;
        end else begin
            if (pop_low) begin
                low_reg <= data_word;
            end
            if (pop_high) begin
                ts_timestamp <= new_ts;
                ts_delta     <= new_delta;
                ts_first     <= new_first;
            end
            if (accept) begin
                prev_ts <= ts_timestamp;
            end
        end
    end

    // clear is applied last so it overrides a coincident handshake or flag set.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev_valid      <= 1'b0;
            record_count    <= '0;
            non_monotonic   <= 1'b0;
            delta_saturated <= 1'b0;
        end else begin
            if (accept) begin
                prev_valid   <= 1'b1;
                record_count <= record_count + 32'd1;
            end
            if (pop_high && new_saturated) begin
                delta_saturated <= 1'b1;
            end
            if (pop_high && new_non_monotonic) begin
                non_monotonic <= 1'b1;
            end
            if (clear) begin
                prev_valid      <= 1'b0;
                record_count    <= '0;
                non_monotonic   <= 1'b0;
                delta_saturated <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_shim_trigger_log_reader.sv
// Directed bench: FIFO model feeding log words, scoreboard of expected records checked on ts_valid.
module tb_shim_trigger_log_reader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        data_word_rd_en;
    logic [31:0] data_word;
    logic        data_buf_empty;
    logic        clear;
    logic        ts_valid;
    logic        ts_ready;
    logic [63:0] ts_timestamp;
    logic [31:0] ts_delta;
    logic        ts_first;
    logic [31:0] record_count;
    logic        non_monotonic;
    logic        delta_saturated;

    always #5 clk = ~clk;

    shim_trigger_log_reader #(
        .DELTA_WIDTH (32)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_word_rd_en (data_word_rd_en),
        .data_word       (data_word),
        .data_buf_empty  (data_buf_empty),
        .clear           (clear),
        .ts_valid        (ts_valid),
        .ts_ready        (ts_ready),
        .ts_timestamp    (ts_timestamp),
        .ts_delta        (ts_delta),
        .ts_first        (ts_first),
        .record_count    (record_count),
        .non_monotonic   (non_monotonic),
        .delta_saturated (delta_saturated)
    );

    // First-word-fall-through FIFO model, flushed by the shared reset.
    logic [31:0] mem [0:255];
    logic [7:0]  wr_ptr = 8'd0;
    logic [7:0]  rd_ptr = 8'd0;

    assign data_buf_empty = (wr_ptr == rd_ptr);
    assign data_word      = mem[rd_ptr];

    always @(posedge clk) begin
        if (!resetn) begin
            rd_ptr <= wr_ptr;
        end else if (data_word_rd_en && !data_buf_empty) begin
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    typedef struct packed {
        logic [63:0] ts;
        logic [31:0] delta;
        logic        first;
    } rec_t;

    rec_t        exp_q[$];
    logic [63:0] m_prev;
    logic        m_pv;
    int unsigned m_count;
    logic        m_sat;
    logic        m_nm;
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_prev  = 64'd0;
        m_pv    = 1'b0;
        m_count = 0;
        m_sat   = 1'b0;
        m_nm    = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 8'd1;
    endtask

    // Expected record for timestamp t, assuming records are accepted in push order.
    task automatic model_record(input logic [63:0] t);
        rec_t r;
        r.ts = t;
        if (t == 64'd0 || !m_pv) begin
            r.first = 1'b1;
            r.delta = 32'd0;
        end else if (t >= m_prev) begin
            r.first = 1'b0;
            if (t - m_prev > 64'hFFFF_FFFF) begin
                r.delta = 32'hFFFF_FFFF;
                m_sat   = 1'b1;
            end else begin
                r.delta = 32'(t - m_prev);
            end
        end else begin
            r.first = 1'b0;
            r.delta = 32'd0;
            m_nm    = 1'b1;
        end
        m_prev = t;
        m_pv   = 1'b1;
        m_count++;
        exp_q.push_back(r);
    endtask

    task automatic push_record(input logic [31:0] lo, input logic [31:0] hi);
        push_word(lo);
        push_word(hi);
        model_record({hi, lo});
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear   = 1'b0;
        m_pv    = 1'b0;
        m_count = 0;
        m_sat   = 1'b0;
        m_nm    = 1'b0;
    endtask

    // Waits (bounded) for a record, compares it with the scoreboard head.
    task automatic get_record(input string tag);
        rec_t r;
        for (int i = 0; i < 200 && !ts_valid; i++) @(negedge clk);
        chk({tag, "_valid"}, 64'(ts_valid), 64'd1);
        if (ts_valid && exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk({tag, "_ts"}, ts_timestamp, r.ts);
            chk({tag, "_delta"}, 64'(ts_delta), 64'(r.delta));
            chk({tag, "_first"}, 64'(ts_first), 64'(r.first));
        end
        if (ts_ready) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        clear    = 1'b0;
        ts_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(ts_valid), 64'd0);
        chk("rst_ts", ts_timestamp, 64'd0);
        chk("rst_delta", 64'(ts_delta), 64'd0);
        chk("rst_first", 64'(ts_first), 64'd0);
        chk("rst_count", 64'(record_count), 64'd0);
        chk("rst_nm", 64'(non_monotonic), 64'd0);
        chk("rst_sat", 64'(delta_saturated), 64'd0);
        chk("rst_rd_en", 64'(data_word_rd_en), 64'd0);
        resetn = 1'b1;

        // Zero timestamp then 100 ticks later.
        ts_ready = 1'b1;
        push_record(32'h0, 32'h0);
        push_record(32'h64, 32'h0);
        get_record("t1a");
        get_record("t1b");
        chk("t1_count", 64'(record_count), 64'(m_count));

        // Interval beyond 32 bits clamps.
        do_clear();
        push_record(32'h10, 32'h0);
        push_record(32'h5, 32'h2);
        get_record("t2a");
        get_record("t2b");
        chk("t2_sat", 64'(delta_saturated), 64'(m_sat));
        chk("t2_nm", 64'(non_monotonic), 64'(m_nm));

        // Backwards step, then clear.
        do_clear();
        push_record(32'd500, 32'h0);
        push_record(32'd200, 32'h0);
        get_record("t3a");
        get_record("t3b");
        chk("t3_nm", 64'(non_monotonic), 64'(m_nm));
        chk("t3_count", 64'(record_count), 64'(m_count));
        do_clear();
        chk("t3_clr_nm", 64'(non_monotonic), 64'd0);
        chk("t3_clr_sat", 64'(delta_saturated), 64'd0);
        chk("t3_clr_count", 64'(record_count), 64'd0);

        // Backpressure: record held, nothing popped while more words wait.
        ts_ready = 1'b0;
        push_record(32'd1000, 32'h0);
        push_record(32'd3000, 32'h0);
        get_record("t4a");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 64'(ts_valid), 64'd1);
            chk("t4_hold_ts", ts_timestamp, 64'd1000);
            chk("t4_hold_rd_en", 64'(data_word_rd_en), 64'd0);
        end
        chk("t4_no_pop", 64'(8'(wr_ptr - rd_ptr)), 64'd2);
        ts_ready = 1'b1;
        @(negedge clk);
        chk("t4_resume_pop", 64'(data_word_rd_en), 64'd1);
        get_record("t4b");

        // High word arrives late: stall, then valid one cycle after its pop.
        push_word(32'h10);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t5_stall_valid", 64'(ts_valid), 64'd0);
            chk("t5_stall_rd_en", 64'(data_word_rd_en), 64'd0);
        end
        push_word(32'h1);
        model_record(64'h1_0000_0010);
        @(negedge clk);
        chk("t5_latency", 64'(ts_valid), 64'd1);
        get_record("t5");

        // Reset while waiting for a high word.
        push_word(32'h5);
        repeat (3) @(negedge clk);
        resetn = 1'b0;
        model_reset();
        exp_q.delete();
        repeat (2) @(negedge clk);
        chk("t6_rst_count", 64'(record_count), 64'd0);
        chk("t6_rst_valid", 64'(ts_valid), 64'd0);
        resetn = 1'b1;
        push_record(32'h0, 32'h0);
        get_record("t6");
        chk("t6_count", 64'(record_count), 64'(m_count));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/shim_trigger_log_reader.md
# shim_trigger_log_reader

Consumes the 32-bit trigger log words that the trigger core writes into the trigger data FIFO, two words per logged trigger: low half, then high half of the 64-bit trigger timer. Reassembles each record into a 64-bit timestamp and computes the saturated interval since the previous record. Presents each record on a valid/ready stream toward the PS-side readout logic. Keeps a record count and sticky integrity flags.

## Interface
- DELTA_WIDTH, 32, width of the inter-trigger interval output; saturates at all-ones.
- clk  in  1  clock.
- resetn  in  1  reset; synchronous, active-low.
- data_word_rd_en  out  1  FIFO pop; combinational.
- data_word  in  32  FIFO head word; first-word-fall-through, valid whenever data_buf_empty=0.
- data_buf_empty  in  1  FIFO empty.
- clear  in  1  single-cycle stats clear; pulsed alongside the trigger core's count-reset command.
- ts_valid  out  1  record available.
- ts_ready  in  1  consumer accepts record.
- ts_timestamp  out  64  {high word, low word}.
- ts_delta  out  DELTA_WIDTH  ticks since the previous accepted record.
- ts_first  out  1  record starts a new timeline: timestamp is 0, or no previous record exists.
- record_count  out  32  accepted records since reset or clear; wraps.
- non_monotonic  out  1  sticky: a nonzero timestamp was smaller than the previous one.
- delta_saturated  out  1  sticky: some ts_delta was clamped.

## Operation
- States:
  - S_RESET: one cycle after reset, then S_LOW.
  - S_LOW: wait for the low word.
  - S_HIGH: wait for the high word.
  - S_OUT: hold the record until it is accepted.
- data_word_rd_en = (state==S_LOW || state==S_HIGH) && !data_buf_empty.
- In S_LOW, when the FIFO is non-empty: latch data_word into low_reg, go to S_HIGH.
- In S_HIGH, when the FIFO is non-empty, on the same edge:
  - ts_timestamp <= {data_word, low_reg}.
  - Compute delta and flags from that value and prev_ts (rules below).
  - Go to S_OUT.
- Delta computation for new timestamp T:
  - T==0 or prev_valid==0: ts_first=1, ts_delta=0.
  - T>=prev_ts: ts_first=0, ts_delta=min(T-prev_ts, 2^DELTA_WIDTH-1). If clamped, set delta_saturated.
  - T<prev_ts and T!=0: ts_first=0, ts_delta=0, set non_monotonic.
- In S_OUT, ts_valid=1 and the registered outputs are held stable. On ts_valid && ts_ready:
  - prev_ts <= ts_timestamp, prev_valid <= 1, record_count += 1.
  - Go to S_LOW.
- clear:
  - Zeroes record_count, prev_valid, non_monotonic and delta_saturated.
  - Does not affect state, the FIFO, or a held record.
  - Clear coinciding with a handshake: clear wins; count=0 and prev_valid=0.
- Both sticky flags are cleared only by reset or clear.

## Timing
- Reset values: all outputs 0; state S_RESET; prev_ts=0, prev_valid=0, low_reg=0.
- Latency: the high word is popped at edge N; ts_valid=1 from cycle N+1.
- Throughput: at most one record per 3 cycles (pop low, pop high, handshake). The producer needs at least 4 cycles per record, so this is sufficient.
- No pop occurs in S_OUT or S_RESET. A FIFO that is empty between the two words stalls in S_HIGH indefinitely, with no timeout.
- ts_valid is never dropped before the handshake, and outputs do not change while ts_valid=1 && !ts_ready.
- Reset mid-record discards the partial record. The FIFO shares resetn, so word pairing realigns.
- ts_delta arithmetic: 64-bit subtraction; the saturation compare covers the upper 64-DELTA_WIDTH bits.

## Structure
- Shared package (shim_trigger_pkg): state encoding, LOG_WORDS_PER_RECORD=2, timestamp width 64.
- One natural sub-module: shim_ts_delta. It is combinational: from T, prev_ts and prev_valid it produces delta, first, saturated and non_monotonic.

## Test plan
- Words 0x0,0x0 then 0x64,0x0, ready=1 → records (0, delta 0, first=1) and (100, delta 100, first=0); record_count=2.
- Words 0x10,0x0 then 0x5,0x2 → second record T=0x2_00000005, delta=0xFFFFFFFF, delta_saturated=1.
- Records T=500 then T=200 → second record delta=0, non_monotonic=1. A subsequent clear deasserts the flag and zeroes record_count.
- ts_ready=0 for 10 cycles with more words queued → outputs stable, no data_word_rd_en. Pops resume in the cycle after the handshake.
- Empty FIFO after the low word for 20 cycles → FSM stays in S_HIGH. Pushing the high word produces ts_valid on the next cycle with the correct 64-bit value.
- resetn low while in S_HIGH, then a fresh record 0,0 → clean restart: record_count=1, first=1.
